// File: rtl/fmap_pingpong_buffer.sv
// Inter-layer feature-map buffer: gathers lane-interleaved per-kernel pixels into a bank,
// then replays the bank one channel at a time in raster order (optionally ping-ponging two banks).
module fmap_pingpong_buffer #(
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int BitSize            = 32,
    parameter int ImageWidth         = 4,
    parameter int DoubleBuffer       = 1,
    parameter int ChannelGap         = 0,
    localparam int ChW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic                                   clk,
    input  logic                                   res_n,
    input  logic [NumberOfK-1:0]                   in_valid,
    input  logic [ProcessingElements*BitSize-1:0]  in_data,
    output logic                                   in_ready,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BitSize-1:0]                     out_data,
    output logic [ChW-1:0]                         out_channel,
    output logic                                   out_last,
    output logic                                   image_done,
    output logic                                   overflow,
    output logic [1:0]                             dbg_drain_state
);

    localparam int NumBanks  = (DoubleBuffer != 0) ? 2 : 1;
    localparam int MapSize   = ImageWidth * ImageWidth;
    localparam int BankWords = NumberOfK * MapSize;
    localparam int MemWords  = NumBanks * BankWords;
    localparam int MemAw     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int PixW      = (MapSize > 1) ? $clog2(MapSize) : 1;
    localparam int CntW      = $clog2(MapSize + 1);
    localparam int GapW      = (ChannelGap > 0) ? $clog2(ChannelGap + 1) : 1;
    localparam int GapLast   = (ChannelGap > 0) ? ChannelGap - 1 : 0;
    localparam int LastChan  = NumberOfK - 1;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_STREAM,
        DRAIN_GAP
    } drain_state_t;

    logic [BitSize-1:0] mem [MemWords];
    bank_state_t        bank_state [NumBanks];
    logic [CntW-1:0]    cnt [NumberOfK];
    logic [CntW-1:0]    cnt_next [NumberOfK];
    logic [NumberOfK-1:0] wr_en;
    logic [NumberOfK-1:0] wr_drop;
    logic               fill_found;
    logic               fill_bank;
    logic               fill_done;

    // Full banks waiting to drain, oldest at q_head; with at most two banks the
    // second entry (when present) is always the other bank.
    logic [1:0]         q_count;
    logic               q_head;

    drain_state_t       state;
    logic               drain_bank;
    logic [ChW-1:0]     chan;
    logic [PixW-1:0]    pix;
    logic [PixW-1:0]    pix_inc;
    logic [GapW-1:0]    gap_cnt;
    logic               drain_start;
    logic               drain_done;

    function automatic logic [MemAw-1:0] word_addr(input logic bank,
                                                   input logic [ChW-1:0] c,
                                                   input logic [PixW-1:0] p);
        return MemAw'(bank) * MemAw'(BankWords) + MemAw'(c) * MemAw'(MapSize) + MemAw'(p);
    endfunction

    // A FILLING bank keeps priority; otherwise the lowest-index FREE bank takes writes.
    always_comb begin
        fill_found = 1'b0;
        fill_bank  = 1'b0;
        for (int b = NumBanks - 1; b >= 0; b--) begin
            if (bank_state[b] == BANK_FREE) begin
                fill_found = 1'b1;
                fill_bank  = b[0];
            end
        end
        for (int b = 0; b < NumBanks; b++) begin
            if (bank_state[b] == BANK_FILLING) begin
                fill_found = 1'b1;
                fill_bank  = b[0];
            end
        end
    end

    assign in_ready = fill_found;

    always_comb begin
        fill_done = |wr_en;
        wr_en     = '0;
        wr_drop   = '0;
        for (int k = 0; k < NumberOfK; k++) begin
            wr_en[k]    = in_valid[k] && fill_found && (cnt[k] != CntW'(MapSize));
            wr_drop[k]  = in_valid[k] && !wr_en[k];
            cnt_next[k] = cnt[k] + CntW'(wr_en[k]);
            if (cnt_next[k] != CntW'(MapSize)) begin
                fill_done = 1'b0;
            end
        end
        fill_done = fill_done && (|wr_en);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NumberOfK; k++) begin
            if (wr_en[k]) begin
                mem[word_addr(fill_bank, ChW'(k), PixW'(cnt[k]))] <=
                    in_data[(k % ProcessingElements) * BitSize +: BitSize];
            end
        end
    end

    assign drain_start = (state == DRAIN_IDLE) && (q_count != 2'd0);
    assign drain_done  = (state == DRAIN_STREAM) && out_ready &&
                         (pix == PixW'(MapSize - 1)) && (chan == ChW'(LastChan));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int k = 0; k < NumberOfK; k++) begin
                cnt[k] <= '0;
            end
            for (int b = 0; b < NumBanks; b++) begin
                bank_state[b] <= BANK_FREE;
            end
            q_count  <= 2'd0;
            q_head   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (|wr_drop) begin
                overflow <= 1'b1;
            end
            for (int k = 0; k < NumberOfK; k++) begin
                cnt[k] <= fill_done ? '0 : cnt_next[k];
            end
            for (int b = 0; b < NumBanks; b++) begin
                if (drain_done && drain_bank == b[0]) begin
                    bank_state[b] <= BANK_FREE;
                end else if (drain_start && q_head == b[0]) begin
                    bank_state[b] <= BANK_DRAINING;
                end else if (fill_bank == b[0] && |wr_en) begin
                    bank_state[b] <= fill_done ? BANK_FULL : BANK_FILLING;
                end
            end
            case ({fill_done, drain_start})
                2'b10: begin
                    if (q_count == 2'd0) begin
                        q_head <= fill_bank;
                    end
                    q_count <= q_count + 2'd1;
                end
                2'b01: begin
                    q_head  <= (NumBanks > 1) ? ~q_head : 1'b0;
                    q_count <= q_count - 2'd1;
                end
                2'b11: q_head <= fill_bank;
                default: ;
            endcase
        end
    end

    assign pix_inc = pix + PixW'(1);

    // Output handshake: a pixel moves when out_valid & out_ready in the same cycle; while
    // out_valid is high and out_ready low, out_data/out_channel/out_last hold their values.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state       <= DRAIN_IDLE;
            drain_bank  <= 1'b0;
            chan        <= '0;
            pix         <= '0;
            gap_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
            image_done  <= 1'b0;
        end else begin
            image_done <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (q_count != 2'd0) begin
                        state       <= DRAIN_STREAM;
                        drain_bank  <= q_head;
                        chan        <= '0;
                        pix         <= '0;
                        out_valid   <= 1'b1;
                        out_channel <= '0;
                        out_last    <= (MapSize == 1);
                        out_data    <= mem[word_addr(q_head, '0, '0)];
                    end
                end
                DRAIN_STREAM: begin
                    if (out_ready) begin
                        if (pix != PixW'(MapSize - 1)) begin
                            pix      <= pix_inc;
                            out_data <= mem[word_addr(drain_bank, chan, pix_inc)];
                            out_last <= (pix_inc == PixW'(MapSize - 1));
                        end else if (chan != ChW'(LastChan)) begin
                            pix  <= '0;
                            chan <= chan + ChW'(1);
                            if (ChannelGap > 0) begin
                                state     <= DRAIN_GAP;
                                gap_cnt   <= '0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end else begin
                                out_channel <= chan + ChW'(1);
                                out_data    <= mem[word_addr(drain_bank, chan + ChW'(1), '0)];
                                out_last    <= (MapSize == 1);
                            end
                        end else begin
                            state      <= DRAIN_IDLE;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            image_done <= 1'b1;
                        end
                    end
                end
                DRAIN_GAP: begin
                    if (gap_cnt == GapW'(GapLast)) begin
                        state       <= DRAIN_STREAM;
                        out_valid   <= 1'b1;
                        out_channel <= chan;
                        out_data    <= mem[word_addr(drain_bank, chan, '0)];
                        out_last    <= (MapSize == 1);
                    end else begin
                        gap_cnt <= gap_cnt + GapW'(1);
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

    assign dbg_drain_state = state;

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Bench for fmap_pingpong_buffer: a single-bank instance (no gap) and a ping-pong instance
// (ChannelGap=3) share one clock; a per-instance scoreboard checks every transferred pixel.
`timescale 1ns/1ps
module tb_fmap_pingpong_buffer;

    localparam int K   = 2;
    localparam int PE  = 2;
    localparam int BS  = 8;
    localparam int IW  = 2;
    localparam int MAP = IW * IW;
    localparam int EW  = BS + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              res_n       [2];
    logic [K-1:0]      in_valid    [2];
    logic [PE*BS-1:0]  in_data     [2];
    logic              in_ready    [2];
    logic              out_valid   [2];
    logic              out_ready   [2];
    logic [BS-1:0]     out_data    [2];
    logic [0:0]        out_channel [2];
    logic              out_last    [2];
    logic              image_done  [2];
    logic              overflow    [2];
    logic [1:0]        dbg_state   [2];

    fmap_pingpong_buffer #(
        .NumberOfK(K), .ProcessingElements(PE), .BitSize(BS), .ImageWidth(IW),
        .DoubleBuffer(0), .ChannelGap(0)
    ) u_single (
        .clk(clk), .res_n(res_n[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_channel(out_channel[0]), .out_last(out_last[0]),
        .image_done(image_done[0]), .overflow(overflow[0]), .dbg_drain_state(dbg_state[0])
    );

    fmap_pingpong_buffer #(
        .NumberOfK(K), .ProcessingElements(PE), .BitSize(BS), .ImageWidth(IW),
        .DoubleBuffer(1), .ChannelGap(3)
    ) u_pingpong (
        .clk(clk), .res_n(res_n[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_channel(out_channel[1]), .out_last(out_last[1]),
        .image_done(image_done[1]), .overflow(overflow[1]), .dbg_drain_state(dbg_state[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    logic [BS-1:0] img [K][MAP];
    int            rdy_mode [2];
    int            n_out    [2];
    int            n_done   [2];
    bit            done_exp [2];
    bit            stall_pend [2];
    logic [EW-1:0] stall_val  [2];
    bit            gap_track  [2];
    int            gap_cnt    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] q_pop(input int d);
        return (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    function automatic void q_flush(input int d);
        if (d == 0) exp_q0.delete();
        else exp_q1.delete();
    endfunction

    // Reference model: a whole image replays channel by channel, pixels in write order.
    task automatic push_image(input int d);
        logic [EW-1:0] e;
        for (int c = 0; c < K; c++) begin
            for (int p = 0; p < MAP; p++) begin
                e = {1'(p == MAP - 1), 1'(c), img[c][p]};
                if (d == 0) exp_q0.push_back(e);
                else exp_q1.push_back(e);
            end
        end
    endtask

    task automatic set_seq_image();
        for (int c = 0; c < K; c++)
            for (int p = 0; p < MAP; p++)
                img[c][p] = BS'(c * MAP + p + 1);
    endtask

    task automatic set_rand_image();
        for (int c = 0; c < K; c++)
            for (int p = 0; p < MAP; p++)
                img[c][p] = BS'($urandom_range(0, 255));
    endtask

    task automatic write_image(input int d, input bit rnd, input bit chk_ready, output int t_last);
        int            idx [K];
        int            guard;
        bit            busy;
        logic [K-1:0]  v;
        logic [PE*BS-1:0] dat;
        guard  = 0;
        t_last = cyc;
        busy   = 1'b1;
        for (int k = 0; k < K; k++) idx[k] = 0;
        while (busy && guard < 2000) begin
            v   = '0;
            dat = '0;
            if (chk_ready) check("in_ready_during_fill", in_ready[d], 1);
            if (in_ready[d]) begin
                for (int k = 0; k < K; k++) begin
                    if (idx[k] < MAP && (!rnd || $urandom_range(0, 1) == 1)) begin
                        v[k] = 1'b1;
                        dat[(k % PE) * BS +: BS] = img[k][idx[k]];
                        idx[k]++;
                    end
                end
            end
            in_valid[d] = v;
            in_data[d]  = dat;
            if (v != '0) t_last = cyc;
            @(posedge clk); #1;
            guard++;
            busy = 1'b0;
            for (int k = 0; k < K; k++) if (idx[k] < MAP) busy = 1'b1;
        end
        in_valid[d] = '0;
        check("fill_timeout", 32'(busy), 0);
        push_image(d);
    endtask

    task automatic drive(input int d, input logic [K-1:0] v, input logic [BS-1:0] l0,
                         input logic [BS-1:0] l1);
        in_valid[d] = v;
        in_data[d]  = {l1, l0};
        @(posedge clk); #1;
        in_valid[d] = '0;
    endtask

    task automatic wait_done(input int d, input int target, input int budget);
        int k;
        k = 0;
        while (n_done[d] < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_timeout", 32'(n_done[d] >= target), 1);
        check("queue_empty", 32'(q_size(d)), 0);
    endtask

    task automatic monitor_step(input int d);
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        act = {out_last[d], out_channel[d], out_data[d]};
        if (!res_n[d]) begin
            q_flush(d);
            done_exp[d]   = 1'b0;
            stall_pend[d] = 1'b0;
            gap_track[d]  = 1'b0;
            if (image_done[d]) check("image_done_in_reset", image_done[d], 0);
        end else begin
            if (image_done[d] || done_exp[d]) check("image_done", image_done[d], 32'(done_exp[d]));
            if (image_done[d]) n_done[d]++;
            done_exp[d] = 1'b0;
            if (stall_pend[d]) begin
                check("stall_valid_hold", out_valid[d], 1);
                check("stall_data_hold", act, stall_val[d]);
            end
            if (gap_track[d]) begin
                if (!out_valid[d]) gap_cnt[d]++;
                else begin
                    check("channel_gap_len", 32'(gap_cnt[d]), (d == 0) ? 0 : 3);
                    gap_track[d] = 1'b0;
                end
            end
            if (out_valid[d] && out_ready[d]) begin
                n_tests++;
                if (q_size(d) == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: dut %0d got 0x%0h, expected nothing (cycle %0d)",
                             d, act, cyc);
                end else begin
                    n_tests--;
                    e = q_pop(d);
                    check("out_pixel", act, e);
                    if (e[EW-1] && e[EW-2]) done_exp[d] = 1'b1;
                    else if (e[EW-1]) begin
                        gap_track[d] = 1'b1;
                        gap_cnt[d]   = 0;
                    end
                end
                n_out[d]++;
                stall_pend[d] = 1'b0;
            end else if (out_valid[d]) begin
                stall_pend[d] = 1'b1;
                stall_val[d]  = act;
            end else begin
                stall_pend[d] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_step(0);
        monitor_step(1);
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            ph++;
            for (int d = 0; d < 2; d++) begin
                case (rdy_mode[d])
                    1:       out_ready[d] = (ph % 3 == 0);
                    2:       out_ready[d] = ($urandom_range(0, 1) == 1);
                    3:       out_ready[d] = (ph % 2 == 0);
                    default: out_ready[d] = 1'b1;
                endcase
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int base;
        for (int d = 0; d < 2; d++) begin
            res_n[d]     = 1'b0;
            in_valid[d]  = '0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
            rdy_mode[d]  = 0;
            n_out[d]     = 0;
            n_done[d]    = 0;
            done_exp[d]  = 1'b0;
            stall_pend[d] = 1'b0;
            gap_track[d] = 1'b0;
            gap_cnt[d]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_out_valid", out_valid[d], 0);
            check("rst_out_last", out_last[d], 0);
            check("rst_image_done", image_done[d], 0);
            check("rst_overflow", overflow[d], 0);
            check("rst_out_channel", out_channel[d], 0);
            check("rst_out_data", out_data[d], 0);
            check("rst_in_ready", in_ready[d], 1);
        end
        res_n[0] = 1'b1;
        res_n[1] = 1'b1;
        @(posedge clk); #1;

        // Single bank: exact latency and image_done timing.
        set_seq_image();
        write_image(0, 1'b0, 1'b0, t);
        check("full_in_ready_low", in_ready[0], 0);
        check("latency_valid_t1", out_valid[0], 0);
        while (cyc < t + 10) begin
            @(posedge clk); #1;
            check("stream_valid", out_valid[0], 32'((cyc - t) >= 2 && (cyc - t) <= 9));
            check("image_done_time", image_done[0], 32'((cyc - t) == 10));
        end
        check("in_ready_at_done", in_ready[0], 1);

        // Backpressure 1,0,0 pattern.
        rdy_mode[0] = 1;
        write_image(0, 1'b0, 1'b0, t);
        wait_done(0, n_done[0] + 1, 400);
        rdy_mode[0] = 0;

        // Write while the single bank is full is dropped and flags overflow.
        write_image(0, 1'b0, 1'b0, t);
        drive(0, 2'b01, 8'd9, 8'd0);
        check("overflow_set_full", overflow[0], 1);
        wait_done(0, n_done[0] + 1, 400);
        check("overflow_sticky", overflow[0], 1);

        // Reset in the middle of draining.
        set_rand_image();
        base = n_out[0];
        write_image(0, 1'b0, 1'b0, t);
        for (int i = 0; i < 50 && n_out[0] < base + 3; i++) begin
            @(posedge clk); #1;
        end
        check("mid_drain_reached", 32'(n_out[0] >= base + 3), 1);
        res_n[0] = 1'b0;
        #1;
        check("reset_valid_drop", out_valid[0], 0);
        check("reset_in_ready", in_ready[0], 1);
        check("reset_overflow_clr", overflow[0], 0);
        base = n_done[0];
        repeat (3) @(posedge clk);
        #1;
        res_n[0] = 1'b1;
        check("no_done_after_reset", 32'(n_done[0]), 32'(base));
        @(posedge clk); #1;
        rdy_mode[0] = 2;
        set_rand_image();
        write_image(0, 1'b1, 1'b0, t);
        wait_done(0, n_done[0] + 1, 400);
        rdy_mode[0] = 0;

        // Kernel 0 written past its map size while kernel 1 is still filling.
        set_rand_image();
        drive(0, 2'b11, img[0][0], img[1][0]);
        for (int p = 1; p < MAP; p++) drive(0, 2'b01, img[0][p], 8'd0);
        check("overflow_pre", overflow[0], 0);
        drive(0, 2'b01, 8'hEE, 8'd0);
        check("overflow_kernel_full", overflow[0], 1);
        check("in_ready_filling", in_ready[0], 1);
        for (int p = 1; p < MAP; p++) drive(0, 2'b10, 8'd0, img[1][p]);
        push_image(0);
        wait_done(0, n_done[0] + 1, 400);

        // Ping-pong: A drains at half rate while B fills with in_ready held high.
        rdy_mode[1] = 3;
        base = n_done[1];
        set_rand_image();
        write_image(1, 1'b0, 1'b0, t);
        set_rand_image();
        write_image(1, 1'b0, 1'b1, t);
        wait_done(1, base + 2, 600);
        check("pingpong_no_overflow", overflow[1], 0);

        // Randomised fills and backpressure on the ping-pong instance.
        rdy_mode[1] = 2;
        base = n_done[1];
        for (int n = 0; n < 6; n++) begin
            set_rand_image();
            write_image(1, 1'b1, 1'b0, t);
        end
        wait_done(1, base + 6, 3000);
        check("random_no_overflow", overflow[1], 0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
